// File: rtl/port_arbiter.sv
// ---------------------------------------------------------------------------
// port_arbiter
//
// Three-way round-robin arbiter feeding one registered output port of a mesh
// router. The requesters are left, bottom and the local PE. A single output
// register holds the flit that is offered downstream. A requester can only win
// when that register is free, meaning it is empty or is being drained this
// cycle. Destination fields travel through untouched because the routing
// decision is made upstream.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   i_valid_{l,b,pe}, i_data_{l,b,pe}
//                                   requester flits (left, bottom, PE)
//   o_ready_{l,b,pe}                combinational accept, one-hot or zero
//   o_valid, o_data                 registered flit offered downstream
//   i_ready                         downstream accepts o_data this cycle
//   o_grant                         index of last winner (0=l, 1=b, 2=pe)
//   o_stall_err                     sticky: downstream stalled STALL_MAX cycles
// ---------------------------------------------------------------------------
module port_arbiter #(
   parameter int x_size      = 2,
   parameter int y_size      = 2,
   parameter int data_width  = 8,
   parameter int total_width = 2*x_size + 2*y_size + data_width,
   parameter int STALL_MAX   = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid_l,
   input  logic                   i_valid_b,
   input  logic                   i_valid_pe,
   input  logic [total_width-1:0] i_data_l,
   input  logic [total_width-1:0] i_data_b,
   input  logic [total_width-1:0] i_data_pe,
   output logic                   o_ready_l,
   output logic                   o_ready_b,
   output logic                   o_ready_pe,
   output logic                   o_valid,
   output logic [total_width-1:0] o_data,
   input  logic                   i_ready,
   output logic [1:0]             o_grant,
   output logic                   o_stall_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   state_e                 state_q;
   logic                   o_valid_q;
   logic [total_width-1:0] o_data_q;
   logic [1:0]             o_grant_q;
   logic [1:0]             ptr_q;
   logic [3:0]             stall_cnt_q, stall_cnt_d;
   logic                   stall_err_q;

   logic [3:0]             req;
   logic                   out_free;
   logic                   win_vld;
   logic [1:0]             win_idx;
   logic                   take;
   logic [total_width-1:0] win_data;

   // Operands are at most 2, so one conditional subtract keeps the result in 0..2.
   function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   // Bit 3 is a constant zero so that any 2-bit index stays inside the vector.
   assign req      = {1'b0, i_valid_pe, i_valid_b, i_valid_l};
   assign out_free = !o_valid_q || i_ready;

   // Scan from the farthest candidate back to ptr so that the candidate
   // closest to ptr in rotation order wins.
   always_comb begin
      // NOTE: give every combinational output a default first so no path leaves it unassigned and a latch is inferred.
      win_vld = 1'b0;
      win_idx = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (req[add_mod3(ptr_q, 2'(k))]) begin
            win_vld = 1'b1;
            win_idx = add_mod3(ptr_q, 2'(k));
         end
      end
   end

   // Requesters are never accepted while rst is high, even between clock edges.
   assign take = win_vld && out_free && !rst;

   always_comb begin
      unique case (win_idx)
         2'd1:    win_data = i_data_b;
         2'd2:    win_data = i_data_pe;
         default: win_data = i_data_l;
      endcase
   end

   assign o_ready_l  = take && (win_idx == 2'd0);
   assign o_ready_b  = take && (win_idx == 2'd1);
   assign o_ready_pe = take && (win_idx == 2'd2);

   // Count the cycles that a held flit is refused downstream. Saturate at 15
   // and clear on every downstream transfer.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q != ST_IDLE) begin
         if (i_ready)                    stall_cnt_d = 4'd0;
         else if (stall_cnt_q != 4'hF)   stall_cnt_d = stall_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         o_valid_q   <= 1'b0;
         // NOTE: o_data is a plain register, not a memory, so it is cleared with the rest of the state.
         o_data_q    <= '0;
         o_grant_q   <= 2'd0;
         ptr_q       <= 2'd0;
         stall_cnt_q <= 4'd0;
         stall_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the pre-edge values.
         if (take) begin
            o_data_q  <= win_data;
            o_grant_q <= win_idx;
            ptr_q     <= add_mod3(win_idx, 2'd1);
         end

         unique case (state_q)
            ST_IDLE: begin
               if (take) begin
                  state_q   <= ST_SEND;
                  o_valid_q <= 1'b1;
               end
            end
            ST_SEND, ST_STALL: begin
               if (take) begin
                  state_q   <= ST_SEND;
                  o_valid_q <= 1'b1;
               end else if (i_ready) begin
                  // Drained with nothing to replace it. o_data keeps its last value.
                  state_q   <= ST_IDLE;
                  o_valid_q <= 1'b0;
               end else begin
                  state_q   <= ST_STALL;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               o_valid_q <= 1'b0;
            end
         endcase

         stall_cnt_q <= stall_cnt_d;
         if (stall_cnt_d == 4'(STALL_MAX)) stall_err_q <= 1'b1;
      end
   end

   assign o_valid     = o_valid_q;
   assign o_data      = o_data_q;
   assign o_grant     = o_grant_q;
   assign o_stall_err = stall_err_q;

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): x_size, 2, destination X field width; y_size, 2, destination Y field width; data_width, 8, payload width; total_width, 2*x_size+2*y_size+data_width, flit width; STALL_MAX, 15, stall cycles before error flag (4-bit counter).
REQ-002 Ports (name direction width meaning): clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-003 i_valid_l, i_valid_b, i_valid_pe input 1 each: requester flit valid for left, bottom, PE.
REQ-004 i_data_l, i_data_b, i_data_pe input total_width each: requester flits.
REQ-005 o_ready_l, o_ready_b, o_ready_pe output 1 each: requester flit accepted this cycle.
REQ-006 o_valid output 1, o_data output total_width: registered flit to downstream output port.
REQ-007 i_ready input 1: downstream accepts o_data this cycle.
REQ-008 o_grant output 2: index of last granted requester (0=left, 1=bottom, 2=pe); o_stall_err output 1: sticky stall error.

Function
REQ-009 Transfer on requester side SHALL occur when i_valid_x and o_ready_x are both high at a rising clk edge; downstream transfer SHALL occur when o_valid and i_ready are both high.
REQ-010 Output register is "free" when o_valid==0 or i_ready==1; o_ready_x SHALL be low for every requester when not free.
REQ-011 When free, arbiter SHALL assert o_ready_x combinationally for exactly one valid requester, chosen round-robin starting from priority pointer ptr (order ptr, ptr+1, ptr+2 modulo 3).
REQ-012 o_ready_x SHALL never be asserted for a requester whose i_valid_x is low; all o_ready low when no valid requester.
REQ-013 On a requester transfer, o_data SHALL load the winner's flit, o_valid SHALL be 1, o_grant SHALL load winner index, ptr SHALL load (winner+1) mod 3, all at the same edge.
REQ-014 Latency: flit accepted at edge N SHALL appear on o_data/o_valid after edge N; back-to-back flits at full throughput (one per cycle) when i_ready stays high.
REQ-015 When downstream transfers and no requester is valid, o_valid SHALL clear at that edge; o_data holds its value.
REQ-016 While o_valid==1 and i_ready==0, o_data and o_valid SHALL hold unchanged.
REQ-017 State machine: IDLE (o_valid=0), SEND (o_valid=1, last cycle i_ready or fresh load), STALL (o_valid=1, i_ready=0 held); IDLE->SEND on grant; SEND->STALL on i_ready=0; STALL->SEND on i_ready=1 with new grant; SEND/STALL->IDLE on drain with no request.
REQ-018 Stall counter SHALL increment each cycle in STALL, saturate at 15, clear on downstream transfer; o_stall_err SHALL set when counter reaches STALL_MAX and remain set until reset.
REQ-019 ptr value 3 SHALL never occur; ptr updates only on a requester transfer.
REQ-020 Arbiter SHALL not inspect destination fields; routing decision is upstream.

Reset
REQ-021 rst high SHALL immediately (asynchronously) force o_valid=0, o_grant=0, ptr=0, stall counter=0, o_stall_err=0, state IDLE; o_data SHALL reset to 0.
REQ-022 During rst all o_ready_x SHALL be 0; a flit in flight during reset assertion is discarded.
REQ-023 After rst deasserts, first grant SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-024 All three valid continuously, i_ready=1, from reset -> grants 0,1,2,0,1,2 on successive cycles, o_data matching each requester flit one cycle later.
REQ-025 Only i_valid_pe=1 with flit 12'hA53, i_ready=1 -> o_ready_pe=1 that cycle, o_data=12'hA53, o_valid=1 next cycle, o_grant=2, ptr=0.
REQ-026 o_valid=1, i_ready held 0 for 20 cycles with left and bottom valid -> all o_ready low, o_data stable, o_stall_err rises after 15th stall cycle and stays high after i_ready returns.
REQ-027 Flit held, i_ready=1 with no requester valid -> o_valid falls next edge, state IDLE.
REQ-028 rst asserted mid-stream between edges -> o_valid and o_stall_err 0 immediately, next grant after release goes to left (ptr=0).
